// File: rtl/move_keypad.sv
// Keypad front end for player moves: synchronizes and debounces four direction
// buttons, then emits one-cycle move pulses with first-press delay and auto-repeat.
module move_keypad #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 16,
   parameter int unsigned REPEAT_RATE     = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] btn_raw,
   input  logic       move_ready,
   output logic [3:0] move
);

   localparam int unsigned KW = 4;
   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DB_PRE   = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [CW-1:0] DLY_PRE  = CW'(REPEAT_DELAY - 2);
   localparam logic [CW-1:0] RATE_PRE = CW'(REPEAT_RATE - 2);

   typedef enum logic [1:0] {IDLE, ISSUE, DELAY, RATE} state_t;

   logic [KW-1:0] sync1, sync2;
   logic [KW-1:0] cand, stable;
   logic [CW-1:0] db_cnt;
   logic [KW-1:0] key_c;

   state_t        state_q, state_d;
   logic [KW-1:0] cur_q, cur_d;
   logic          first_q, first_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic [KW-1:0] move_d;

   // Two-flop synchronizer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Debouncer: stable follows the candidate once it has been seen DEBOUNCE_CYCLES times
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cand   <= '0;
         stable <= '0;
         db_cnt <= '0;
      end else if (sync2 != cand) begin
         cand   <= sync2;
         db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
         db_cnt <= db_cnt + CW'(1);
         if (db_cnt == DB_PRE) stable <= cand;
      end
   end

   // Lowest set bit gives up > down > left > right priority
   always_comb begin
      key_c = stable & KW'(~stable + KW'(1));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cur_q   <= '0;
         first_q <= 1'b0;
         rcnt_q  <= '0;
         move    <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         first_q <= first_d;
         rcnt_q  <= rcnt_d;
         move    <= move_d;
      end
   end

   // Key changes override repeat timing; a stalled pulse waits in ISSUE
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      first_d = first_q;
      rcnt_d  = rcnt_q;
      move_d  = '0;
      if (state_q == IDLE) begin
         if (key_c != '0) begin
            state_d = ISSUE;
            cur_d   = key_c;
            first_d = 1'b1;
         end
      end else if (key_c == '0) begin
         state_d = IDLE;
      end else if (key_c != cur_q) begin
         state_d = ISSUE;
         cur_d   = key_c;
         first_d = 1'b1;
      end else begin
         case (state_q)
            ISSUE: begin
               if (move_ready) begin
                  move_d  = cur_q;
                  rcnt_d  = '0;
                  state_d = first_q ? DELAY : RATE;
                  first_d = 1'b0;
               end
            end
            DELAY: begin
               rcnt_d = rcnt_q + CW'(1);
               if (rcnt_q == DLY_PRE) state_d = ISSUE;
            end
            RATE: begin
               rcnt_d = rcnt_q + CW'(1);
               if (rcnt_q == RATE_PRE) state_d = ISSUE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_keypad.sv
// Self-checking bench for move_keypad: directed scenarios plus randomized
// stimulus against a deadline-based behavioural model.
module tb_move_keypad;
   localparam int unsigned D  = 4;
   localparam int unsigned RD = 16;
   localparam int unsigned RR = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] btn_raw = 4'b0;
   logic       move_ready = 1'b0;
   logic [3:0] move;

   int checks = 0;
   int errs = 0;
   int cyc = 0;

   // model state
   logic [3:0] sy1, sy2, stab, cur, exp_move;
   logic [3:0] hist[$];
   int         due;
   bit         first;

   int         pc[$];
   logic [3:0] pv[$];

   always #5 clk = ~clk;

   move_keypad #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .rstn(rstn), .btn_raw(btn_raw), .move_ready(move_ready), .move(move)
   );

   function automatic logic [3:0] lowbit(input logic [3:0] v);
      logic [3:0] r;
      bit found;
      r = 4'b0;
      found = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i] && !found) begin
            r[i] = 1'b1;
            found = 1;
         end
      end
      return r;
   endfunction

   function automatic void model_reset();
      sy1 = 4'b0; sy2 = 4'b0; stab = 4'b0; cur = 4'b0;
      exp_move = 4'b0; hist.delete(); due = 0; first = 0;
   endfunction

   // One clock edge: pulse decision uses the key before the edge, then the debouncer advances
   function automatic void model_edge(input logic [3:0] b, input logic r);
      logic [3:0] k, obs;
      bit same;
      k = lowbit(stab);
      exp_move = 4'b0;
      if (cur == 4'b0) begin
         if (k != 4'b0) begin cur = k; due = cyc + 1; first = 1; end
      end else if (k == 4'b0) begin
         cur = 4'b0;
      end else if (k != cur) begin
         cur = k; due = cyc + 1; first = 1;
      end else if (cyc >= due && r) begin
         exp_move = cur;
         due = cyc + (first ? int'(RD) : int'(RR));
         first = 0;
      end
      obs = sy2; sy2 = sy1; sy1 = b;
      hist.push_back(obs);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
         same = 1;
         foreach (hist[i]) if (hist[i] != obs) same = 0;
         if (same) stab = obs;
      end
   endfunction

   task automatic step(input logic [3:0] b, input logic r, input logic rn);
      @(negedge clk);
      btn_raw = b; move_ready = r; rstn = rn;
      @(posedge clk);
      cyc++;
      if (!rn) model_reset(); else model_edge(b, r);
      #1;
      checks++;
      if (move !== exp_move) begin
         errs++;
         $display("FAIL move cyc=%0d got=%b exp=%b", cyc, move, exp_move);
      end
      if (move !== 4'b0) begin pc.push_back(cyc); pv.push_back(move); end
   endtask

   task automatic clear_log();
      pc.delete(); pv.delete();
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      checks++;
      if (move !== 4'b0) begin errs++; $display("FAIL reset_value got=%b exp=0000", move); end
      for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b1);
   endtask

   task automatic test_single_hold();
      int e;
      int off[4] = '{7, 23, 31, 39};
      clear_log();
      step(4'b0001, 1'b1, 1'b1);
      e = cyc;
      for (int i = 1; i < 40; i++) step(4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
      checks++;
      if (pc.size() != 4) begin errs++; $display("FAIL hold_count got=%0d exp=4", pc.size()); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= pc.size()) begin
            errs++; $display("FAIL hold_pulse%0d missing exp_cyc=%0d", k, e + off[k]);
         end else if (pc[k] != e + off[k] || pv[k] !== 4'b0001) begin
            errs++; $display("FAIL hold_pulse%0d got cyc=%0d val=%b exp cyc=%0d val=0001", k, pc[k], pv[k], e + off[k]);
         end
      end
   endtask

   task automatic test_glitch();
      clear_log();
      for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
      checks++;
      if (pc.size() != 0) begin errs++; $display("FAIL glitch_pulses got=%0d exp=0", pc.size()); end
   endtask

   task automatic test_priority();
      int e2, p0, p1;
      clear_log();
      for (int i = 0; i < 30; i++) step(4'b0110, 1'b1, 1'b1);
      checks++;
      if (pc.size() != 2) begin errs++; $display("FAIL prio_count got=%0d exp=2", pc.size()); end
      foreach (pv[i]) begin
         checks++;
         if (pv[i] !== 4'b0010) begin errs++; $display("FAIL prio_value got=%b exp=0010", pv[i]); end
      end
      clear_log();
      step(4'b0100, 1'b1, 1'b1);
      e2 = cyc;
      for (int i = 1; i < 40; i++) step(4'b0100, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
      p0 = -1; p1 = -1;
      foreach (pc[i]) if (pv[i] === 4'b0100) begin
         if (p0 < 0) p0 = pc[i]; else if (p1 < 0) p1 = pc[i];
      end
      checks++;
      if (p0 != e2 + 7) begin errs++; $display("FAIL prio_switch_first got=%0d exp=%0d", p0, e2 + 7); end
      checks++;
      if (p1 != e2 + 23) begin errs++; $display("FAIL prio_switch_second got=%0d exp=%0d", p1, e2 + 23); end
   endtask

   task automatic test_backpressure();
      int e;
      clear_log();
      step(4'b1000, 1'b0, 1'b1);
      e = cyc;
      for (int i = 1; i < 20; i++) step(4'b1000, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) step(4'b1000, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
      checks++;
      if (pc.size() < 2 || pc[0] != e + 20 || pc[1] != e + 36 || pv[0] !== 4'b1000) begin
         errs++;
         $display("FAIL stall_pulses got n=%0d first=%0d second=%0d exp first=%0d second=%0d",
                  pc.size(), pc.size() > 0 ? pc[0] : -1, pc.size() > 1 ? pc[1] : -1, e + 20, e + 36);
      end
   endtask

   task automatic test_reset_mid();
      int rel, first_p;
      clear_log();
      for (int i = 0; i < 8; i++) step(4'b0001, 1'b1, 1'b1);
      checks++;
      if (move !== 4'b0001) begin errs++; $display("FAIL rmid_pre got=%b exp=0001", move); end
      rstn = 1'b0;
      model_reset();
      #1;
      checks++;
      if (move !== 4'b0) begin errs++; $display("FAIL rmid_async got=%b exp=0000", move); end
      for (int i = 0; i < 2; i++) step(4'b0001, 1'b1, 1'b0);
      clear_log();
      step(4'b0001, 1'b1, 1'b1);
      rel = cyc;
      for (int i = 1; i < 30; i++) step(4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
      first_p = (pc.size() > 0) ? pc[0] : -1;
      checks++;
      if (first_p != rel + 7) begin errs++; $display("FAIL rmid_latency got=%0d exp=%0d", first_p, rel + 7); end
   endtask

   task automatic test_single_press();
      int e;
      clear_log();
      step(4'b0001, 1'b1, 1'b1);
      e = cyc;
      for (int i = 1; i < 10; i++) step(4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 30; i++) step(4'b0000, 1'b1, 1'b1);
      checks++;
      if (pc.size() != 1 || pc[0] != e + 7) begin
         errs++; $display("FAIL single_press got n=%0d exp n=1 at %0d", pc.size(), e + 7);
      end
      clear_log();
      step(4'b0001, 1'b1, 1'b1);
      e = cyc;
      for (int i = 1; i < 12; i++) step(4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
      checks++;
      if (pc.size() != 1 || pc[0] != e + 7) begin
         errs++; $display("FAIL repress_idle got n=%0d exp n=1 at %0d", pc.size(), e + 7);
      end
   endtask

   task automatic test_random();
      logic [3:0] b;
      int hold, mode;
      for (int s = 0; s < 70; s++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0: b = 4'b0;
            1, 2: b = 4'(1 << $urandom_range(0, 3));
            default: b = 4'($urandom_range(0, 15));
         endcase
         hold = $urandom_range(1, 30);
         if ($urandom_range(0, 19) == 0) begin
            for (int i = 0; i < 2; i++) step(b, 1'b1, 1'b0);
         end
         for (int i = 0; i < hold; i++) step(b, ($urandom_range(0, 3) != 0), 1'b1);
      end
      for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_single_hold();
      test_glitch();
      test_priority();
      test_backpressure();
      test_reset_mid();
      test_single_press();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule

// File: doc/move_keypad.md
MOVE_KEYPAD -- requirements
Module: move_keypad

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples required before the key vector is accepted; legal range 2..65535.
REQ-002 Parameter REPEAT_DELAY, default 16: cycles from the first pulse of a held key to its first auto-repeat pulse; legal range 2..65535.
REQ-003 Parameter REPEAT_RATE, default 8: cycles between subsequent auto-repeat pulses; legal range 2..65535.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 btn_raw  input  4  asynchronous buttons: bit0 up, bit1 down, bit2 left, bit3 right; 1 = pressed.
REQ-007 move_ready  input  1  downstream player_move can take a move this cycle.
REQ-008 move  output  4  registered move request; one-hot or zero; a one-cycle pulse per move; same bit map as btn_raw.

Function
REQ-009 btn_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Debouncer: candidate register plus 16-bit counter; a synchronized value different from the candidate SHALL load the candidate and clear the counter.
REQ-011 Debouncer: the counter SHALL increment while the synchronized value equals the candidate; stable SHALL load the candidate on the edge where the counter reaches DEBOUNCE_CYCLES-1; the counter SHALL saturate there.
REQ-012 key = lowest set bit of stable (priority up > down > left > right), zero when stable is zero; simultaneous presses therefore yield exactly one direction.
REQ-013 FSM states: IDLE, ISSUE, DELAY, RATE; reset state IDLE.
REQ-014 IDLE: key nonzero -> ISSUE, latching key as cur.
REQ-015 ISSUE: move_ready sampled 1 -> move=cur for exactly one cycle, repeat counter cleared, next state DELAY if arrived from IDLE, RATE otherwise.
REQ-016 ISSUE: move_ready sampled 0 -> move=0 and stay in ISSUE; the pulse is deferred, never dropped.
REQ-017 DELAY/RATE: counter increments each cycle; on reaching REPEAT_DELAY-1 (DELAY) or REPEAT_RATE-1 (RATE) -> ISSUE; successive pulses are therefore exactly REPEAT_DELAY, then REPEAT_RATE, cycles apart while move_ready stays 1.
REQ-018 Any state except IDLE: key == 0 -> IDLE with no further pulse; key nonzero and != cur -> ISSUE with cur=key and treated as first press (DELAY follows).
REQ-019 Latency: with move_ready=1, btn_raw first sampled 1 at edge E, and held, move SHALL be high exactly during the cycle after edge E+DEBOUNCE_CYCLES+3.
REQ-020 move SHALL be zero in every cycle except the single pulse cycles defined above; at most one bit set.
REQ-021 Glitches on btn_raw shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse.

Reset
REQ-022 rstn low SHALL immediately force move=0, state IDLE, synchronizer, candidate, stable and all counters to 0, independent of clk.
REQ-023 Reset mid-operation (any state) SHALL discard any pending pulse; after release, a still-held button SHALL re-debounce and produce a first pulse with REQ-019 latency.

Verification
REQ-024 Defaults, move_ready=1, btn_raw=0001 held 40 cycles from edge E -> move=0001 at cycle after E+7, then after E+23, E+31, E+39; zero elsewhere.
REQ-025 btn_raw=0010 for 3 cycles then 0 -> move stays 0000 throughout.
REQ-026 btn_raw=0110 held -> only 0010 pulses; change to 0100 -> 0100 pulse after debounce, next 0100 pulse 16 cycles later.
REQ-027 btn_raw=1000 held, move_ready=0 for 20 cycles then 1 -> exactly one 1000 pulse in the cycle after ready is sampled 1, next one 16 cycles later.
REQ-028 btn_raw=0001 held, rstn pulsed low 2 cycles inside DELAY -> move 0000 immediately and during reset; first pulse after release at cycle after release-edge+7.
REQ-029 Press 0001, release after its first pulse, before REPEAT_DELAY -> exactly one pulse, FSM returns to IDLE.
